// File: rtl/arith_pkg.sv
// Shared encodings for the bit-serial arithmetic blocks.
//   ORDER_LSB / ORDER_MSB : which end of the word the first serial bit lands in
//   buf_state_e           : single-entry output buffer occupancy
package arith_pkg;

  localparam bit ORDER_LSB = 1'b1;
  localparam bit ORDER_MSB = 1'b0;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / word-out bus of the deserializer.
//   clr, in_valid, in_bit, out_ready : driven by the surrounding logic (master)
//   in_ready, out_valid, out_data,
//   bit_cnt                          : driven by the deserializer (slave)
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output clr, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, bit_cnt
  );

  modport slave (
    input  clr, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, bit_cnt
  );

endinterface

// File: rtl/sipo_word_buf.sv
// Single-entry output word buffer with EMPTY/FULL occupancy FSM.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : a frame completes this cycle; capture load_data_i
//   load_data_i  : fully assembled word
//   last_bit_i   : the frame counter sits on its final bit
//   out_ready_i  : consumer takes the held word this cycle
//   out_valid_o  : held word is valid
//   out_data_o   : held word (keeps the last word when not valid)
//   in_ready_c   : combinational; low only when the final bit would overrun a stalled word
module sipo_word_buf
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             last_bit_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             in_ready_c
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: a completion always refills, even while draining
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (load_i) state_d = BUF_FULL;
      BUF_FULL:  if (!load_i && out_ready_i) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid_o = (state_q == BUF_FULL);
    in_ready_c  = !(last_bit_i && (state_q == BUF_FULL) && !out_ready_i);
  end

  // Word register; a load only occurs when the slot is free or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      data_q <= '0;
    else if (load_i) data_q <= load_data_i;
  end

  assign out_data_o = data_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with frame counter and backpressure.
//   clk    : rising-edge clock
//   rst_n  : async active-low reset
//   bus    : slave side of sipo_deserializer_if
//            (clr, in_valid/in_ready/in_bit, out_valid/out_ready/out_data, bit_cnt)
// Parameters: WIDTH (2..64), LSB_FIRST (1: first bit lands in out_data[0]).
module sipo_deserializer
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  sipo_deserializer_if.slave   bus
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam bit               ORDER = LSB_FIRST ? ORDER_LSB : ORDER_MSB;

  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit, accept, complete, in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  assign last_bit = (cnt_q == LAST);
  assign accept   = bus.in_valid && in_ready;
  // clr overrides any same-cycle accept, so it can never complete a frame
  assign complete = accept && !bus.clr && last_bit;

  // Shift register contents once the current bit is included
  always_comb begin
    if (ORDER == ORDER_LSB) shifted = {bus.in_bit, shift_q[WIDTH-1:1]};
    else                    shifted = {shift_q[WIDTH-2:0], bus.in_bit};
  end

  // Shifter and frame counter next state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = shifted;
      cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  sipo_word_buf #(
    .WIDTH (WIDTH)
  ) u_word_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (complete),
    .load_data_i (shifted),
    .last_bit_i  (last_bit),
    .out_ready_i (bus.out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .in_ready_c  (in_ready)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench: one LSB-first and one MSB-first deserializer share the same stimulus
// and are compared every cycle against a frame-level model.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr, in_valid, in_bit, out_ready;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W)) if_l ();
  sipo_deserializer_if #(.WIDTH(W)) if_m ();

  assign if_l.clr = clr;  assign if_l.in_valid = in_valid;
  assign if_l.in_bit = in_bit;  assign if_l.out_ready = out_ready;
  assign if_m.clr = clr;  assign if_m.in_valid = in_valid;
  assign if_m.in_bit = in_bit;  assign if_m.out_ready = out_ready;

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(if_l));
  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(if_m));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a word is the accepted bits placed by arrival index
  int             m_cnt    = 0;
  logic           m_valid  = 1'b0;
  logic [W-1:0]   m_word_l = '0;
  logic [W-1:0]   m_word_m = '0;
  bit             frame[W];

  function automatic bit m_ready();
    return !(m_cnt == W - 1 && m_valid && !out_ready);
  endfunction

  initial begin
    bit rdy, done;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_valid = 1'b0; m_word_l = '0; m_word_m = '0;
      end else begin
        cyc++;
        rdy  = m_ready();
        done = 1'b0;
        if (clr) m_cnt = 0;
        else if (in_valid && rdy) begin
          frame[m_cnt] = in_bit;
          if (m_cnt == W - 1) begin done = 1'b1; m_cnt = 0; end
          else m_cnt++;
        end
        if (done) begin
          m_word_l = '0; m_word_m = '0;
          for (int i = 0; i < W; i++) if (frame[i]) begin
            m_word_l = m_word_l | (W'(1) << i);
            m_word_m = m_word_m | (W'(1) << (W - 1 - i));
          end
          m_valid = 1'b1;
        end else if (m_valid && out_ready) m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    #1;
    if (rst_n && cmp_en) begin
      chk("l_out_valid", if_l.out_valid, m_valid);
      chk("l_out_data",  if_l.out_data,  m_word_l);
      chk("l_bit_cnt",   if_l.bit_cnt,   64'(m_cnt));
      chk("l_in_ready",  if_l.in_ready,  m_ready());
      chk("m_out_valid", if_m.out_valid, m_valid);
      chk("m_out_data",  if_m.out_data,  m_word_m);
      chk("m_bit_cnt",   if_m.bit_cnt,   64'(m_cnt));
      chk("m_in_ready",  if_m.in_ready,  m_ready());
    end
  end

  task automatic send_bit(input logic b);
    bit acc = 1'b0;
    int tries = 0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!acc) begin
      #1;
      acc = if_l.in_ready;
      @(negedge clk);
      tries++;
      if (!acc && tries > 20) begin
        checks++; errors++;
        $display("FAIL send_bit_timeout actual=stalled expected=accepted at %0t", $time);
        return;
      end
    end
  endtask

  task automatic send_byte(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2;
    logic [7:0] nxt;
    clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", if_l.out_valid, 1'b0);
    chk("rst_bit_cnt",   if_l.bit_cnt,   3'd0);
    chk("rst_out_data",  if_l.out_data,  8'h00);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", if_l.in_ready, 1'b1);
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic frame, both bit orders
    send_byte(8'h4D);
    #2;
    chk("t1_valid",  if_l.out_valid, 1'b1);
    chk("t1_data_l", if_l.out_data,  8'h4D);
    chk("t1_data_m", if_m.out_data,  8'hB2);
    chk("t1_cnt",    if_l.bit_cnt,   3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 chk("t1_pulse", if_l.out_valid, 1'b0);
    @(negedge clk);

    // Backpressure on the final bit only
    out_ready = 1'b0;
    send_byte(8'h4D);
    nxt = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(nxt[i]);
    #2;
    chk("bp_held_valid", if_l.out_valid, 1'b1);
    chk("bp_held_data",  if_l.out_data,  8'h4D);
    in_bit = nxt[7];
    #1;
    chk("bp_in_ready_low", if_l.in_ready, 1'b0);
    chk("bp_cnt7",         if_l.bit_cnt,  3'd7);
    repeat (3) @(negedge clk);
    #2;
    chk("bp_stable_data", if_l.out_data, 8'h4D);
    chk("bp_stable_cnt",  if_l.bit_cnt,  3'd7);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_high", if_l.in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("bp_next_valid", if_l.out_valid, 1'b1);
    chk("bp_next_data",  if_l.out_data,  8'hA5);
    chk("bp_next_cnt",   if_l.bit_cnt,   3'd0);
    @(negedge clk);
    #2 chk("bp_drained", if_l.out_valid, 1'b0);
    @(negedge clk);

    // Back-to-back frames
    send_byte(8'hFF);
    #2;
    chk("s_ff", if_l.out_data, 8'hFF);
    t1 = cyc;
    send_byte(8'h00);
    #2;
    t2 = cyc;
    chk("s_00_valid", if_l.out_valid, 1'b1);
    chk("s_00",       if_l.out_data,  8'h00);
    chk("s_spacing",  64'(t2 - t1),   64'd8);
    in_valid = 1'b0;
    @(negedge clk);

    // Frame restart
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #2 chk("clr_cnt", if_l.bit_cnt, 3'd0);
    send_byte(8'hA5);
    #2;
    chk("clr_data_l", if_l.out_data, 8'hA5);
    chk("clr_data_m", if_m.out_data, 8'hA5);
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-frame with a pending word
    out_ready = 1'b0;
    send_byte(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", if_l.out_valid, 1'b0);
    chk("ar_cnt",   if_l.bit_cnt,   3'd0);
    chk("ar_data",  if_l.out_data,  8'h00);
    chk("ar_data_m", if_m.out_data, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    #2 chk("ar_in_ready", if_l.in_ready, 1'b1);
    send_byte(8'h96);
    #2;
    chk("ar_next_l", if_l.out_data, 8'h96);
    chk("ar_next_m", if_m.out_data, 8'h69);
    in_valid = 1'b0;
    @(negedge clk);

    // Randomised traffic
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      clr       = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end
    in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
